// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch (I) and data (D) ports.
// It holds one transaction at a time, routes the response back to the owner, and has a hang watchdog.
//
// state  | meaning
// IDLE   | no transaction outstanding, m_req low
// BUSY_I | fetch command latched and presented on the memory bus
// BUSY_D | data command latched and presented on the memory bus
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_write,
   input  logic        i_extend,
   input  logic [1:0]  i_width,
   input  logic [31:0] i_wdata,
   output logic        i_ack,
   output logic        i_error,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_write,
   input  logic        d_extend,
   input  logic [1:0]  d_width,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_error,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic        m_write,
   output logic        m_extend,
   output logic [1:0]  m_width,
   output logic [31:0] m_wdata,
   input  logic        m_ack,
   input  logic        m_error,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   state_t      state, state_nxt;
   logic        last_grant, last_grant_nxt;   // 0 = fetch, 1 = data
   logic [7:0]  tcount, tcount_nxt;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        cmd_write, cmd_extend;
   logic [1:0]  cmd_width;
   logic        load_i, load_d;
   logic        timeout;

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      tcount_nxt     = tcount;
      load_i         = 1'b0;
      load_d         = 1'b0;
      i_ack          = 1'b0;
      i_error        = 1'b0;
      d_ack          = 1'b0;
      d_error        = 1'b0;
      timeout        = (TIMEOUT_CYCLES != 0) && (tcount == TIMEOUT_LIM) && !m_ack;

      case (state)
         IDLE: begin
            if (d_req && (!i_req || !last_grant))
               load_d = 1'b1;
            else if (i_req)
               load_i = 1'b1;
         end
         BUSY_I: begin
            if (m_ack) begin
               i_ack   = i_req;
               i_error = i_req && m_error;
               if (d_req)
                  load_d = 1'b1;
               else
                  state_nxt = IDLE;
            end else if (timeout) begin
               i_ack     = i_req;
               i_error   = i_req;
               state_nxt = IDLE;
            end else if (tcount != 8'hFF) begin
               tcount_nxt = tcount + 8'd1;
            end
         end
         BUSY_D: begin
            if (m_ack) begin
               d_ack   = d_req;
               d_error = d_req && m_error;
               if (i_req)
                  load_i = 1'b1;
               else
                  state_nxt = IDLE;
            end else if (timeout) begin
               d_ack     = d_req;
               d_error   = d_req;
               state_nxt = IDLE;
            end else if (tcount != 8'hFF) begin
               tcount_nxt = tcount + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A grant, from IDLE or back-to-back after an ack, always restarts the watchdog
      if (load_i) begin
         state_nxt      = BUSY_I;
         last_grant_nxt = 1'b0;
         tcount_nxt     = '0;
      end
      if (load_d) begin
         state_nxt      = BUSY_D;
         last_grant_nxt = 1'b1;
         tcount_nxt     = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         tcount     <= '0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_write  <= 1'b0;
         cmd_extend <= 1'b0;
         cmd_width  <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         tcount     <= tcount_nxt;
         if (load_i) begin
            cmd_addr   <= i_addr;
            cmd_wdata  <= i_wdata;
            cmd_write  <= i_write;
            cmd_extend <= i_extend;
            cmd_width  <= i_width;
         end else if (load_d) begin
            cmd_addr   <= d_addr;
            cmd_wdata  <= d_wdata;
            cmd_write  <= d_write;
            cmd_extend <= d_extend;
            cmd_width  <= d_width;
         end
      end
   end

   assign m_req    = (state != IDLE);
   assign busy     = (state != IDLE);
   assign m_addr   = cmd_addr;
   assign m_wdata  = cmd_wdata;
   assign m_write  = cmd_write;
   assign m_extend = cmd_extend;
   assign m_width  = cmd_width;
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single memory bus between the instruction-fetch port and the data port driven by the memory stage. Only one transaction is in flight at a time. The block latches the winning command, holds it stable on the memory bus until the memory acknowledges, and routes ack/error/read data back to the granted requester. Contention is resolved round-robin, and a watchdog counter converts a hung bus transaction into an error response.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without `m_ack` before a forced error; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch address.
- i_write, i_extend  in  1  fetch write flag and sign-extend flag (i_write is normally 0).
- i_width  in  2  fetch access width (0 byte, 1 half, 2 word).
- i_wdata  in  32  fetch write data.
- i_ack, i_error  out  1  fetch completion and fault.
- i_rdata  out  32  fetch read data.
- d_req, d_addr, d_write, d_extend, d_width, d_wdata  in  same widths as the i_ set  data-port request and command.
- d_ack, d_error  out  1  data-port completion and fault.
- d_rdata  out  32  data-port read data.
- m_req  out  1  memory request.
- m_addr  out  32  memory address.
- m_write, m_extend  out  1  memory write and sign-extend flags.
- m_width  out  2  memory access width.
- m_wdata  out  32  memory write data.
- m_ack, m_error  in  1  memory completion and fault.
- m_rdata  in  32  memory read data.
- busy  out  1  high while a transaction is outstanding.

## Operation
State machine with three states:
- IDLE: `m_req`=0.
  - If exactly one of `i_req`/`d_req` is high, grant it.
  - If both are high, grant the one opposite `last_grant`.
  - On a grant, latch that requester's addr/write/wdata/extend/width into the command register, record it in `last_grant`, clear `tcount`, and go to BUSY_I or BUSY_D.
- BUSY_I / BUSY_D:
  - `m_req`=1 and `m_*` command outputs are driven from the latched register, so they are stable regardless of requester changes.
  - `tcount` increments each cycle without `m_ack`.
- Completion (`m_ack`=1 in BUSY_x):
  - If the granted requester's `x_req` is still 1, drive `x_ack`=1, `x_error`=`m_error`, `x_rdata`=`m_rdata` combinationally in the same cycle.
  - If `x_req` has dropped (the requester abandoned the access), assert no response; the result is discarded.
  - Next state: if the other requester's req is high, grant it directly (back-to-back, no bubble). Otherwise go to IDLE.
  - The just-served requester is never re-granted in its ack cycle.
- Timeout (TIMEOUT_CYCLES≠0, `tcount`==TIMEOUT_CYCLES, and no `m_ack` this cycle):
  - Drive `x_ack`=1 and `x_error`=1 if `x_req` is high.
  - Drop `m_req` and go to IDLE.
  - If `m_ack` and timeout coincide, `m_ack` wins.
- Ungranted requester: `ack`=0, `error`=0. All `rdata` outputs pass `m_rdata` unconditionally (qualified by ack).
- `busy` = state≠IDLE.
- `tcount` is 8 bits wide (sized to TIMEOUT_CYCLES) and saturates; it never wraps.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, `last_grant`=I, `tcount`=0, command register all zeros.
  - So `m_req`=0, `m_addr`=0, `m_wdata`=0, `m_write`=0, `m_extend`=0, `m_width`=0, `busy`=0.
  - `i_ack`/`d_ack`/`i_error`/`d_error`=0. With `last_grant`=I, the first tie is won by the data port.
- Reset while BUSY: the transaction is abandoned and `m_req` falls immediately. The memory must tolerate this.
- Latency: requester raises req in cycle N (IDLE) → `m_req` rises at cycle N+1 → with a zero-wait memory (`m_ack` in N+1), requester ack is in N+1. Minimum is 1 cycle.
- Same requester back-to-back with no competitor: one IDLE bubble between transactions.
- Alternating requesters: zero bubble.
- Requesters must hold req and command until ack, or drop req to abandon. The arbiter never re-reads the command after grant.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=0x100, memory acks 2 cycles after `m_req` with rdata 0xDEADBEEF → `m_addr`=0x100 from cycle 1, `i_ack`=1 and `i_rdata`=0xDEADBEEF in cycle 3, `d_ack` stays 0.
- Tie after reset: `i_req` and `d_req` both high in cycle 0, zero-wait memory → D served first (cycle 1), I served in cycle 2 with no bubble, and `last_grant`=I.
- Command stability: after grant, change `d_addr` from 0x200 to 0x300 while the memory stalls for 4 cycles → `m_addr` stays 0x200 throughout.
- Abandon: drop `d_req` in the second BUSY cycle, memory acks in the fourth → `m_req` held until the ack, `d_ack` never asserts, state returns to IDLE.
- Timeout: TIMEOUT_CYCLES=4, memory never acks → in the 5th BUSY cycle `d_ack`=1 and `d_error`=1, then `m_req`=0 and `busy`=0 the next cycle.
- Fault passthrough plus async reset: `m_ack`=1 with `m_error`=1 → `i_error`=1 in the same cycle. Asserting reset mid-BUSY drops `m_req` and `busy` without waiting for a clock edge.
